// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: effective address, memory handshake, load extension.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of masking them.
module lsu_mem_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_store,
  input  logic [2:0]        func3,
  input  logic [11:0]       imm,
  input  logic [63:0]       rs1_data,
  input  logic [63:0]       rs2_data,
  input  logic [4:0]        rd_idx,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  output logic              out_valid,
  output logic [4:0]        out_rd_idx,
  output logic [63:0]       out_data,
  output logic              out_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        func3_q, func3_d;
  logic [2:0]        lane_q, lane_d;
  logic              store_q, store_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;
  logic [7:0]        mem_wstrb_q, mem_wstrb_d;
  logic              out_valid_q, out_valid_d;
  logic [4:0]        out_rd_idx_q, out_rd_idx_d;
  logic [63:0]       out_data_q, out_data_d;
  logic              out_fault_q, out_fault_d;

  logic [ADDR_W-1:0] ea_raw, ea;
  logic [2:0]        amask;
  logic [7:0]        smask;
  logic              legal, misal;
  logic [63:0]       shifted, ext;
  logic              unused_bits;

  assign unused_bits = ^rs1_data[63:ADDR_W];

  always_comb begin
    ea_raw = rs1_data[ADDR_W-1:0] + {{(ADDR_W-12){imm[11]}}, imm};
    unique case (func3[1:0])
      2'b00:   begin amask = 3'b000; smask = 8'h01; end
      2'b01:   begin amask = 3'b001; smask = 8'h03; end
      2'b10:   begin amask = 3'b011; smask = 8'h0f; end
      default: begin amask = 3'b111; smask = 8'hff; end
    endcase
    legal = is_store ? !func3[2] : (func3 != 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
    misal = |(ea_raw[2:0] & amask);
    ea    = ea_raw;
`else
    misal = 1'b0;
    ea    = ea_raw & ~{{(ADDR_W-3){1'b0}}, amask};
`endif
  end

  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (func3_q)
      3'b000:  ext = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  ext = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  ext = {56'd0, shifted[7:0]};
      3'b101:  ext = {48'd0, shifted[15:0]};
      3'b110:  ext = {32'd0, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    func3_d      = func3_q;
    lane_d       = lane_q;
    store_d      = store_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    out_rd_idx_d = out_rd_idx_q;
    out_data_d   = out_data_q;
    out_fault_d  = out_fault_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d        = '0;
          func3_d      = func3;
          lane_d       = ea[2:0];
          store_d      = is_store;
          mem_we_d     = is_store;
          mem_addr_d   = {ea[ADDR_W-1:3], 3'b000};
          mem_wdata_d  = rs2_data << {ea[2:0], 3'b000};
          mem_wstrb_d  = smask << ea[2:0];
          out_rd_idx_d = rd_idx;
          out_data_d   = '0;
          out_fault_d  = 1'b0;
          if (!legal || misal) begin
            state_d     = RESP;
            out_fault_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_gnt) begin
          state_d = store_q ? RESP : WAIT;
        end else if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
          state_d     = RESP;
          out_fault_d = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          state_d    = RESP;
          out_data_d = ext;
        end else if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
          state_d     = RESP;
          out_fault_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered copies of the next state.
    in_ready_d  = (state_d == IDLE);
    mem_req_d   = (state_d == REQ);
    out_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      func3_q      <= '0;
      lane_q       <= '0;
      store_q      <= 1'b0;
      in_ready_q   <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      out_valid_q  <= 1'b0;
      out_rd_idx_q <= '0;
      out_data_q   <= '0;
      out_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      func3_q      <= func3_d;
      lane_q       <= lane_d;
      store_q      <= store_d;
      in_ready_q   <= in_ready_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      out_valid_q  <= out_valid_d;
      out_rd_idx_q <= out_rd_idx_d;
      out_data_q   <= out_data_d;
      out_fault_q  <= out_fault_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign out_valid  = out_valid_q;
  assign out_rd_idx = out_rd_idx_q;
  assign out_data   = out_data_q;
  assign out_fault  = out_fault_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: memory handshake, extension, faults,
// timeout and reset during an access.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, is_store;
  logic [2:0]  func3;
  logic [11:0] imm;
  logic [63:0] rs1_data, rs2_data;
  logic [4:0]  rd_idx;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;
  logic        out_valid, out_fault;
  logic [4:0]  out_rd_idx;
  logic [63:0] out_data;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_store(is_store), .func3(func3), .imm(imm),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_idx(rd_idx),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_rd_idx(out_rd_idx),
    .out_data(out_data), .out_fault(out_fault)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        fault;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("out_rd_idx", 64'(out_rd_idx), 64'(mon_e.rd));
        check("out_data", out_data, mon_e.data);
        check("out_fault", 64'(out_fault), 64'(mon_e.fault));
        check("latency", 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
      end
    end
  end

  task automatic wait_done(string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check({tag, "_no_completion"}, 64'd0, 64'd1);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(string tag, logic st, logic [2:0] f3, logic [11:0] im,
                     logic [63:0] r1, logic [63:0] r2, logic [4:0] rd,
                     int gd, int rvd, logic [63:0] rdat,
                     logic [31:0] eaddr, logic [63:0] ewd, logic [7:0] ews,
                     logic [63:0] edata, logic efault);
    int lat;
    is_store = st; func3 = f3; imm = im;
    rs1_data = r1; rs2_data = r2; rd_idx = rd;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = efault ? 1 : (st ? 2 + gd : 3 + gd + rvd);
    sb.push_back(exp_t'{rd, edata, efault, lat, cyc});
    if (efault) begin
      @(negedge clk);
      check({tag, "_no_req"}, 64'(mem_req), 64'd0);
    end else begin
      @(negedge clk);
      check({tag, "_req"}, 64'(mem_req), 64'd1);
      check({tag, "_busy"}, 64'(in_ready), 64'd0);
      check({tag, "_addr"}, 64'(mem_addr), 64'(eaddr));
      check({tag, "_we"}, 64'(mem_we), 64'(st));
      if (st) begin
        check({tag, "_wdata"}, mem_wdata, ewd);
        check({tag, "_wstrb"}, 64'(mem_wstrb), 64'(ews));
      end
      repeat (gd) begin @(posedge clk); #1; end
      if (gd > 0) begin
        check({tag, "_stall_req"}, 64'(mem_req), 64'd1);
        check({tag, "_stall_addr"}, 64'(mem_addr), 64'(eaddr));
      end
      mem_gnt = 1'b1;
      @(posedge clk);
      #1;
      mem_gnt = 1'b0;
      if (!st) begin
        repeat (rvd) begin @(posedge clk); #1; end
        mem_rdata = rdat;
        mem_rvalid = 1'b1;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
      end
    end
    wait_done(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; is_store = 1'b0; func3 = '0; imm = '0;
    rs1_data = '0; rs2_data = '0; rd_idx = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_fault", 64'(out_fault), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_wstrb", 64'(mem_wstrb), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run("lw", 0, 3'b010, 12'h004, 64'h1000, 0, 5'd1, 0, 0,
        64'h80000000_00000000, 32'h1000, 0, 0, 64'hFFFFFFFF_80000000, 0);
    run("sb", 1, 3'b000, 12'h000, 64'h2003, 64'hAB, 5'd2, 0, 0, 0,
        32'h2000, 64'h00000000_AB000000, 8'h08, 0, 0);
    run("ld_neg", 0, 3'b011, 12'hFF8, 64'h3010, 0, 5'd3, 2, 3,
        64'hDEADBEEF_CAFEF00D, 32'h3008, 0, 0, 64'hDEADBEEF_CAFEF00D, 0);
    run("sh", 1, 3'b001, 12'h000, 64'h4006, 64'h12345678_9ABCDEF0, 5'd4,
        1, 0, 0, 32'h4000, 64'hDEF00000_00000000, 8'hC0, 0, 0);
    run("lb", 0, 3'b000, 12'h007, 64'h5000, 0, 5'd5, 0, 1,
        64'h85000000_00000000, 32'h5000, 0, 0, 64'hFFFFFFFF_FFFFFF85, 0);
    run("lbu", 0, 3'b100, 12'h007, 64'h5000, 0, 5'd6, 0, 0,
        64'h85000000_00000000, 32'h5000, 0, 0, 64'h85, 0);
    run("sw", 1, 3'b010, 12'h000, 64'h6004, 64'hCAFEBABE, 5'd7, 0, 0, 0,
        32'h6000, 64'hCAFEBABE_00000000, 8'hF0, 0, 0);
    run("sd", 1, 3'b011, 12'h010, 64'h7000, 64'h01234567_89ABCDEF, 5'd8,
        0, 0, 0, 32'h7010, 64'h01234567_89ABCDEF, 8'hFF, 0, 0);
    run("lwu", 0, 3'b110, 12'h004, 64'h8000, 0, 5'd9, 0, 0,
        64'h80000000_00000000, 32'h8000, 0, 0, 64'h80000000, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    run("lhu_mis", 0, 3'b101, 12'h001, 64'h1000, 0, 5'd10, 0, 0, 0,
        0, 0, 0, 0, 1);
`else
    run("lhu_mis", 0, 3'b101, 12'h001, 64'h1000, 0, 5'd10, 0, 0,
        64'h11223344_55668001, 32'h1000, 0, 0, 64'h8001, 0);
`endif
    run("ld_f3_111", 0, 3'b111, 12'h000, 64'h9000, 0, 5'd11, 0, 0, 0,
        0, 0, 0, 0, 1);
    run("st_f3_100", 1, 3'b100, 12'h000, 64'h9000, 0, 5'd12, 0, 0, 0,
        0, 0, 0, 0, 1);

    // Store that never sees a grant.
    is_store = 1'b1; func3 = 3'b011; imm = '0;
    rs1_data = 64'hA000; rs2_data = 64'h55; rd_idx = 5'd13;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back(exp_t'{5'd13, 64'd0, 1'b1, 65, cyc});
    wait_done("timeout");
    check("timeout_req_drop", 64'(mem_req), 64'd0);
    check("timeout_idle", 64'(in_ready), 64'd1);

    // Reset while waiting for read data; the late rvalid must be ignored.
    is_store = 1'b0; func3 = 3'b011; rs1_data = 64'hB000; rd_idx = 5'd14;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    mem_gnt = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_wait_in_ready", 64'(in_ready), 64'd1);
    check("rst_wait_req", 64'(mem_req), 64'd0);
    mem_rdata = 64'h1234;
    mem_rvalid = 1'b1;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_wait_no_valid", 64'(out_valid), 64'd0);
    end
    check("rst_wait_still_idle", 64'(in_ready), 64'd1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
